// File: rtl/mu0_seq_alu_if.sv
// Request/result bundle for the sequential ALU: operands and opcode in,
// registered result, flags and handshake out.
interface mu0_seq_alu_if #(
   parameter int WIDTH = 16
);
   logic             Start;
   logic [2:0]       M;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic [WIDTH-1:0] Q;
   logic             Busy;
   logic             Done;
   logic [3:0]       Flags;

   modport master (
      output Start, M, X, Y,
      input  Q, Busy, Done, Flags
   );

   modport slave (
      input  Start, M, X, Y,
      output Q, Busy, Done, Flags
   );
endinterface

// File: rtl/mu0_seq_alu.sv
// Small ALU: single-cycle add/sub/inc/logic/pass, plus a WIDTH-cycle
// shift-add unsigned multiply. Flags are {N, Z, C, V}.
//
// state | meaning
// IDLE  | waiting for Start; single-cycle ops complete here
// MUL   | one shift-add iteration per clock, cnt counts down to 0
module mu0_seq_alu #(
   parameter int WIDTH = 16
) (
   input  logic         Clk,
   input  logic         nReset,
   mu0_seq_alu_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic {IDLE, MUL} state_t;

   state_t             state, state_nx;
   logic [WIDTH-1:0]   q_r, q_nx;
   logic [3:0]         flags_r, flags_nx;
   logic               done_r, done_nx;
   logic [WIDTH-1:0]   mcand, mcand_nx;
   logic [2*WIDTH-1:0] prod, prod_nx;
   logic [CW-1:0]      cnt, cnt_nx;

   logic [WIDTH-1:0]   b_op;
   logic               cin;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   alu_q;
   logic               alu_c, alu_v;
   logic [WIDTH:0]     step_sum;
   logic [2*WIDTH-1:0] step_prod;

   // add, inc and sub share one adder: inc adds 0 with carry-in, sub adds ~Y with carry-in
   always_comb begin
      b_op = bus.Y;
      cin  = 1'b0;
      case (bus.M)
         3'b010: begin b_op = '0;     cin = 1'b1; end
         3'b011: begin b_op = ~bus.Y; cin = 1'b1; end
         default: ;
      endcase
      sum = {1'b0, bus.X} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
   end

   always_comb begin
      alu_q = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (bus.M)
         3'b000: alu_q = bus.Y;
         3'b001, 3'b010, 3'b011: begin
            alu_q = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
            alu_v = (bus.X[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != bus.X[WIDTH-1]);
         end
         3'b100: alu_q = bus.X & bus.Y;
         3'b101: alu_q = bus.X | bus.Y;
         3'b110: alu_q = bus.X ^ bus.Y;
         default: ;
      endcase
   end

   // prod holds {partial sum, remaining multiplier bits}; each step adds and shifts right
   always_comb begin
      step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
      step_prod = {step_sum, prod[WIDTH-1:1]};
   end

   always_comb begin
      state_nx = state;
      q_nx     = q_r;
      flags_nx = flags_r;
      done_nx  = 1'b0;
      mcand_nx = mcand;
      prod_nx  = prod;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (bus.Start) begin
               if (bus.M == 3'b111) begin
                  mcand_nx = bus.X;
                  prod_nx  = {{WIDTH{1'b0}}, bus.Y};
                  cnt_nx   = CW'(WIDTH - 1);
                  state_nx = MUL;
               end else begin
                  q_nx     = alu_q;
                  flags_nx = {alu_q[WIDTH-1], ~|alu_q, alu_c, alu_v};
                  done_nx  = 1'b1;
               end
            end
         end
         MUL: begin
            prod_nx = step_prod;
            cnt_nx  = cnt - 1'b1;
            if (cnt == '0) begin
               q_nx     = step_prod[WIDTH-1:0];
               flags_nx = {step_prod[WIDTH-1], ~|step_prod[WIDTH-1:0],
                           |step_prod[2*WIDTH-1:WIDTH], 1'b0};
               done_nx  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state   <= IDLE;
         q_r     <= '0;
         flags_r <= '0;
         done_r  <= 1'b0;
         mcand   <= '0;
         prod    <= '0;
         cnt     <= '0;
      end else begin
         state   <= state_nx;
         q_r     <= q_nx;
         flags_r <= flags_nx;
         done_r  <= done_nx;
         mcand   <= mcand_nx;
         prod    <= prod_nx;
         cnt     <= cnt_nx;
      end
   end

   assign bus.Q     = q_r;
   assign bus.Flags = flags_r;
   assign bus.Done  = done_r;
   assign bus.Busy  = (state == MUL);
endmodule
